// File: rtl/bus_arbiter_if.sv
// Handshake and RAM-access bundle shared between the DMA/CPU masters and the bus arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface bus_arbiter_if;
    logic       Bus_req;
    logic       Bus_grant;
    logic       Cpu_Busy;
    logic       Cpu_hold;
    logic       Forced_release;

    logic [7:0] Cpu_Address;
    logic       Cpu_Cs;
    logic       Cpu_WE;
    logic [7:0] Cpu_Data;

    logic [7:0] Dma_Address;
    logic       Dma_Cs;
    logic       Dma_WE;
    logic [7:0] Dma_Data;

    logic [7:0] Ram_Address;
    logic       Ram_Cs;
    logic       Ram_WE;
    logic [7:0] Ram_Data;

    modport slave (
        input  Bus_req, Cpu_Busy,
        input  Cpu_Address, Cpu_Cs, Cpu_WE, Cpu_Data,
        input  Dma_Address, Dma_Cs, Dma_WE, Dma_Data,
        output Bus_grant, Cpu_hold, Forced_release,
        output Ram_Address, Ram_Cs, Ram_WE, Ram_Data
    );

    modport master (
        output Bus_req, Cpu_Busy,
        output Cpu_Address, Cpu_Cs, Cpu_WE, Cpu_Data,
        output Dma_Address, Dma_Cs, Dma_WE, Dma_Data,
        input  Bus_grant, Cpu_hold, Forced_release,
        input  Ram_Address, Ram_Cs, Ram_WE, Ram_Data
    );
endinterface

// File: rtl/bus_arbiter.sv
// CPU/DMA bus arbiter: grants the RAM port to the DMA, caps its tenure at MAX_DMA_CYCLES
// and enforces a CPU-only cooldown after a forced release.
//
//   state    | meaning
//   CPU_OWN  | CPU drives RAM; DMA request considered once cooldown has expired
//   WAIT_REL | DMA requesting, CPU stalled but finishing its current access
//   DMA_OWN  | DMA granted and driving RAM
//   RECLAIM  | one-cycle turnaround, RAM port idle
module bus_arbiter #(
    parameter int MAX_DMA_CYCLES = 64,
    parameter int COOLDOWN       = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    bus_arbiter_if.slave  bus
);

    localparam int HOLD_W = (MAX_DMA_CYCLES > 0) ? $clog2(MAX_DMA_CYCLES + 1) : 1;
    localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_DMA_CYCLES);
    localparam logic [CD_W-1:0]   CD_LOAD  = CD_W'(COOLDOWN);

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        WAIT_REL = 2'd1,
        DMA_OWN  = 2'd2,
        RECLAIM  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [CD_W-1:0]   cd_cnt, cd_nxt;
    logic              forced_q, limit_exit;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= CPU_OWN;
            hold_cnt <= '0;
            cd_cnt   <= '0;
            forced_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            cd_cnt   <= cd_nxt;
            forced_q <= limit_exit;
        end
    end

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        cd_nxt     = cd_cnt;
        limit_exit = 1'b0;

        unique case (state)
            CPU_OWN: begin
                if (cd_cnt != '0) begin
                    cd_nxt = cd_cnt - 1'b1;
                end else if (bus.Bus_req) begin
                    if (bus.Cpu_Busy) begin
                        state_nxt = WAIT_REL;
                    end else begin
                        state_nxt = DMA_OWN;
                        hold_nxt  = HOLD_W'(1);
                    end
                end
            end
            WAIT_REL: begin
                if (!bus.Bus_req) begin
                    state_nxt = CPU_OWN;
                end else if (!bus.Cpu_Busy) begin
                    state_nxt = DMA_OWN;
                    hold_nxt  = HOLD_W'(1);
                end
            end
            DMA_OWN: begin
                // A voluntary release wins over the limit so it never counts as forced.
                if (!bus.Bus_req) begin
                    state_nxt = RECLAIM;
                    hold_nxt  = '0;
                end else if (hold_cnt == HOLD_MAX) begin
                    state_nxt  = RECLAIM;
                    hold_nxt   = '0;
                    limit_exit = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            RECLAIM: begin
                state_nxt = CPU_OWN;
                cd_nxt    = forced_q ? CD_LOAD : '0;
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

    assign bus.Bus_grant      = (state == DMA_OWN);
    assign bus.Cpu_hold       = (state != CPU_OWN);
    assign bus.Forced_release = forced_q;

    always_comb begin
        bus.Ram_Address = '0;
        bus.Ram_Cs      = 1'b0;
        bus.Ram_WE      = 1'b0;
        bus.Ram_Data    = '0;
        unique case (state)
            CPU_OWN, WAIT_REL: begin
                bus.Ram_Address = bus.Cpu_Address;
                bus.Ram_Cs      = bus.Cpu_Cs;
                bus.Ram_WE      = bus.Cpu_WE;
                bus.Ram_Data    = bus.Cpu_Data;
            end
            DMA_OWN: begin
                bus.Ram_Address = bus.Dma_Address;
                bus.Ram_Cs      = bus.Dma_Cs;
                bus.Ram_WE      = bus.Dma_WE;
                bus.Ram_Data    = bus.Dma_Data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a tenure/cooldown reference model.
module tb_bus_arbiter;
    localparam int MAXC = 64;
    localparam int COOL = 4;

    logic Clk = 1'b0;
    logic Rst;
    int   total = 0;
    int   bad   = 0;

    bus_arbiter_if bif ();

    bus_arbiter #(.MAX_DMA_CYCLES(MAXC), .COOLDOWN(COOL)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bif)
    );

    always #5 Clk = ~Clk;

    // Reference model: who owns the bus, how long the DMA has held it,
    // whether a turnaround is in progress and how much cooldown remains.
    int dma_run;
    bit waiting;
    bit turnaround;
    bit was_forced;
    int cool_left;
    bit fix_dma_addr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit req, input bit busy, input bit rst);
        if (rst) begin
            dma_run = 0; waiting = 0; turnaround = 0; was_forced = 0; cool_left = 0;
        end else if (turnaround) begin
            turnaround = 0;
            cool_left  = was_forced ? COOL : 0;
            was_forced = 0;
        end else if (dma_run > 0) begin
            if (!req) begin
                dma_run = 0; turnaround = 1; was_forced = 0;
            end else if (dma_run == MAXC) begin
                dma_run = 0; turnaround = 1; was_forced = 1;
            end else begin
                dma_run++;
            end
        end else if (waiting) begin
            if (!req) waiting = 0;
            else if (!busy) begin
                waiting = 0; dma_run = 1;
            end
        end else if (cool_left > 0) begin
            cool_left--;
        end else if (req) begin
            if (busy) waiting = 1;
            else dma_run = 1;
        end
    endtask

    task automatic step(input bit req, input bit busy, input bit rst);
        logic [17:0] exp_ram;
        bit          granted;
        Rst              = rst;
        bif.Bus_req      = req;
        bif.Cpu_Busy     = busy;
        bif.Cpu_Address  = 8'($urandom);
        bif.Cpu_Cs       = 1'($urandom);
        bif.Cpu_WE       = 1'($urandom);
        bif.Cpu_Data     = 8'($urandom);
        bif.Dma_Address  = fix_dma_addr ? 8'h3C : 8'($urandom);
        bif.Dma_Cs       = 1'($urandom);
        bif.Dma_WE       = 1'($urandom);
        bif.Dma_Data     = 8'($urandom);
        @(posedge Clk);
        model_step(req, busy, rst);
        #1;
        granted = (dma_run > 0);
        if (granted)
            exp_ram = {bif.Dma_Address, bif.Dma_Cs, bif.Dma_WE, bif.Dma_Data};
        else if (turnaround)
            exp_ram = '0;
        else
            exp_ram = {bif.Cpu_Address, bif.Cpu_Cs, bif.Cpu_WE, bif.Cpu_Data};
        check_val("grant",  32'(bif.Bus_grant), 32'(granted));
        check_val("hold",   32'(bif.Cpu_hold), 32'(granted || waiting || turnaround));
        check_val("forced", 32'(bif.Forced_release), 32'(turnaround && was_forced));
        check_val("ram",    32'({bif.Ram_Address, bif.Ram_Cs, bif.Ram_WE, bif.Ram_Data}),
                  32'(exp_ram));
        @(negedge Clk);
    endtask

    initial begin
        int  g_cnt;
        int  f_cnt;
        bit  req_r;
        fix_dma_addr = 0;
        dma_run = 0; waiting = 0; turnaround = 0; was_forced = 0; cool_left = 0;
        @(negedge Clk);

        // Reset state
        step(0, 0, 1);
        step(1, 0, 1);
        check_val("rst_grant", 32'(bif.Bus_grant), 32'(0));
        check_val("rst_hold",  32'(bif.Cpu_hold), 32'(0));

        // Immediate grant, DMA address routed to RAM
        fix_dma_addr = 1;
        step(1, 0, 0);
        check_val("grant_lat1", 32'(bif.Bus_grant), 32'(1));
        check_val("ram_addr_3c", 32'(bif.Ram_Address), 32'h3C);
        repeat (4) step(1, $urandom_range(0, 1), 0);
        fix_dma_addr = 0;
        step(0, 0, 0);
        step(0, 0, 0);

        // CPU busy for three cycles delays the grant
        repeat (3) step(1, 1, 0);
        check_val("wait_nogrant", 32'(bif.Bus_grant), 32'(0));
        step(1, 0, 0);
        check_val("grant_after_busy", 32'(bif.Bus_grant), 32'(1));
        step(0, 0, 0);
        step(0, 0, 0);

        // Limit-forced release, cooldown, regrant
        g_cnt = 0; f_cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1, 0, 0);
            if (i <= 70 && bif.Bus_grant) g_cnt++;
            if (bif.Forced_release) f_cnt++;
            if (i == 65) check_val("reclaim_cs", 32'(bif.Ram_Cs), 32'(0));
            if (i == 70) check_val("cooldown_nogrant", 32'(bif.Bus_grant), 32'(0));
            if (i == 71) check_val("regrant", 32'(bif.Bus_grant), 32'(1));
        end
        check_val("grant_cycles", 32'(g_cnt), 32'(MAXC));
        check_val("forced_pulses", 32'(f_cnt), 32'(1));
        step(0, 0, 0);
        step(0, 0, 0);

        // Voluntary release then immediate re-request: no cooldown
        repeat (10) step(1, 0, 0);
        step(0, 0, 0);
        check_val("vol_no_forced", 32'(bif.Forced_release), 32'(0));
        step(1, 0, 0);
        step(1, 0, 0);
        check_val("vol_regrant", 32'(bif.Bus_grant), 32'(1));
        step(0, 0, 0);
        step(0, 0, 0);

        // Request withdrawn while waiting
        step(1, 1, 0);
        step(0, 1, 0);
        check_val("withdraw_hold", 32'(bif.Cpu_hold), 32'(0));
        step(0, 0, 0);

        // Reset in the middle of a grant
        repeat (5) step(1, 0, 0);
        step(1, 0, 1);
        check_val("midrst_grant", 32'(bif.Bus_grant), 32'(0));
        check_val("midrst_forced", 32'(bif.Forced_release), 32'(0));
        step(1, 0, 0);
        check_val("post_rst_grant", 32'(bif.Bus_grant), 32'(1));

        // Random traffic
        req_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) req_r = ~req_r;
            step(req_r, $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
